// File: rtl/accumulator_stream_pkg.sv
// Shared definitions for the streaming amplitude accumulator: FSM state
// encoding, a constant-evaluable clog2 and the lane-slice helper macro.
// Optional feature macro used by the block: ACCUMULATOR_STREAM_MEAN_OUT_EN.

`ifndef ACC_LANE
`define ACC_LANE(bus, idx, width) bus[(width)*((idx)+1)-1 -: (width)]
`endif

package accumulator_pkg;

   // ACCUM collects beats, HOLD presents a finished total until it is taken
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } accState_e;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/accumulator_stream_if.sv
// Stream bundle for the accumulator: amplitude beats in, vector totals out.
// The out_mean signal only exists when ACCUMULATOR_STREAM_MEAN_OUT_EN is defined.

interface accumulator_stream_if #(
   parameter int NUM_QUBIT  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4
);
   localparam int SUM_W = DATA_WIDTH + NUM_QUBIT;

   logic                        in_valid;
   logic                        in_ready;
   logic [LANES*DATA_WIDTH-1:0] in_data;
   logic                        out_valid;
   logic                        out_ready;
   logic [SUM_W-1:0]            out_sum;
`ifdef ACCUMULATOR_STREAM_MEAN_OUT_EN
   logic [DATA_WIDTH-1:0]       out_mean;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_mean
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_mean
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum
   );
`endif

endinterface

// File: rtl/accumulator_stream_lane_sum.sv
// Combinational adder tree for one input beat: every lane is sign-extended
// to the full sum width before being added, so no intermediate overflow.

module lane_sum #(
   parameter int LANES      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int SUM_W      = 36
) (
   input  logic [LANES*DATA_WIDTH-1:0] data_i,
   output logic [SUM_W-1:0]            sum_o
);

   // Walk the lanes, widening each signed amplitude before accumulating it
   always_comb begin
      sum_o = '0;
      for (int j = 0; j < LANES; j++) begin
         sum_o = sum_o + SUM_W'($signed(`ACC_LANE(data_i, j, DATA_WIDTH)));
      end
   end

endmodule

// File: rtl/accumulator_stream.sv
// Streaming accumulator: sums 2**NUM_QUBIT signed amplitudes arriving LANES
// per beat and hands one registered total per vector to the diffusion stage.
// Define ACCUMULATOR_STREAM_MEAN_OUT_EN to also produce the registered mean.

module accumulator_stream
   import accumulator_pkg::*;
#(
   parameter int NUM_QUBIT  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   accumulator_stream_if.slave s
);

   localparam int SUM_W    = DATA_WIDTH + NUM_QUBIT;
   localparam int BEATS    = (2 ** NUM_QUBIT) / LANES;
   localparam int CNT_BITS = clog2(BEATS);
   localparam int CNT_W    = (CNT_BITS > 1) ? CNT_BITS : 1;

   accState_e        state_q, state_d;
   logic [SUM_W-1:0] acc_q, acc_d;
   logic [SUM_W-1:0] outSum_q, outSum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             outValid_q, outValid_d;
   logic [SUM_W-1:0] beatSum;
   logic [SUM_W-1:0] total;
   logic             inReady;
   logic             beatFire;
   logic             lastBeat;
`ifdef ACCUMULATOR_STREAM_MEAN_OUT_EN
   logic [DATA_WIDTH-1:0] outMean_q, outMean_d;
`endif

   lane_sum #(
      .LANES      (LANES),
      .DATA_WIDTH (DATA_WIDTH),
      .SUM_W      (SUM_W)
   ) u_lane_sum (
      .data_i (s.in_data),
      .sum_o  (beatSum)
   );

   // Handshake decode: a held result that is being consumed frees the input
   // in the same cycle, which keeps back-to-back vectors at full throughput
   always_comb begin
      inReady  = (state_q == ACCUM) || ((state_q == HOLD) && s.out_ready);
      beatFire = s.in_valid && inReady;
      lastBeat = (cnt_q == CNT_W'(BEATS - 1));
      total    = acc_q + beatSum;
   end

   // Next-state logic: flush wins, then retirement of a held result, then
   // the accepted beat (which may immediately produce the next result)
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      outValid_d = outValid_q;
      outSum_d   = outSum_q;
`ifdef ACCUMULATOR_STREAM_MEAN_OUT_EN
      outMean_d  = outMean_q;
`endif
      if (clr) begin
         acc_d      = '0;
         cnt_d      = '0;
         outValid_d = 1'b0;
         state_d    = ACCUM;
      end else begin
         if ((state_q == HOLD) && s.out_ready) begin
            outValid_d = 1'b0;
            state_d    = ACCUM;
         end
         if (beatFire) begin
            if (lastBeat) begin
               outSum_d   = total;
`ifdef ACCUMULATOR_STREAM_MEAN_OUT_EN
               outMean_d  = DATA_WIDTH'($signed(total) >>> NUM_QUBIT);
`endif
               acc_d      = '0;
               cnt_d      = '0;
               outValid_d = 1'b1;
               state_d    = HOLD;
            end else begin
               acc_d = total;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // State and datapath registers, cleared asynchronously by rst_n
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ACCUM;
         acc_q      <= '0;
         cnt_q      <= '0;
         outValid_q <= 1'b0;
         outSum_q   <= '0;
`ifdef ACCUMULATOR_STREAM_MEAN_OUT_EN
         outMean_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         outValid_q <= outValid_d;
         outSum_q   <= outSum_d;
`ifdef ACCUMULATOR_STREAM_MEAN_OUT_EN
         outMean_q  <= outMean_d;
`endif
      end
   end

   assign s.in_ready  = inReady;
   assign s.out_valid = outValid_q;
   assign s.out_sum   = outSum_q;
`ifdef ACCUMULATOR_STREAM_MEAN_OUT_EN
   assign s.out_mean  = outMean_q;
`endif

endmodule

// File: tb/tb_accumulator_stream.sv
// Self-checking bench for accumulator_stream. A queue-based model collects
// accepted amplitudes and computes the vector total and mean arithmetically.

module tb_accumulator_stream;

   localparam int NUM_QUBIT  = 4;
   localparam int DATA_WIDTH = 32;
   localparam int LANES      = 4;
   localparam int SUM_W      = DATA_WIDTH + NUM_QUBIT;
   localparam int AMPS       = 2 ** NUM_QUBIT;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;

   int testCount = 0;
   int failCount = 0;

   longint                ampQ[$];
   bit                    expPending;
   logic [SUM_W-1:0]      expSum;
   logic [DATA_WIDTH-1:0] expMean;

   accumulator_stream_if #(
      .NUM_QUBIT  (NUM_QUBIT),
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES)
   ) bus ();

   accumulator_stream #(
      .NUM_QUBIT  (NUM_QUBIT),
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .s     (bus)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      ampQ.delete();
      expPending = 1'b0;
      expSum     = '0;
      expMean    = '0;
   endtask

   task automatic checkOutput();
      checkValue("out_valid", {63'd0, bus.out_valid}, {63'd0, expPending});
      checkValue("out_sum", 64'(bus.out_sum), 64'(expSum));
`ifdef ACCUMULATOR_STREAM_MEAN_OUT_EN
      checkValue("out_mean", 64'(bus.out_mean), 64'(expMean));
`endif
   endtask

   // One clock cycle: drive inputs after a falling edge, check in_ready,
   // update the model at the rising edge, check outputs at the next fall
   task automatic applyStimulus(input bit v, input logic [LANES*DATA_WIDTH-1:0] d,
                                input bit ordy, input bit c);
      bit     expReady;
      longint total;
      longint shifted;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = ordy;
      clr           = c;
      #1;
      expReady = !expPending || ordy;
      checkValue("in_ready", {63'd0, bus.in_ready}, {63'd0, expReady});
      @(posedge clk);
      if (c) begin
         ampQ.delete();
         expPending = 1'b0;
      end else begin
         if (expPending && ordy) expPending = 1'b0;
         if (v && expReady) begin
            for (int j = 0; j < LANES; j++) begin
               logic [DATA_WIDTH-1:0] lane;
               lane = d[DATA_WIDTH*j +: DATA_WIDTH];
               ampQ.push_back(longint'($signed(lane)));
            end
            if (ampQ.size() == AMPS) begin
               total = 0;
               foreach (ampQ[k]) total += ampQ[k];
               shifted    = total >>> NUM_QUBIT;
               expSum     = total[SUM_W-1:0];
               expMean    = shifted[DATA_WIDTH-1:0];
               expPending = 1'b1;
               ampQ.delete();
            end
         end
      end
      @(negedge clk);
      checkOutput();
   endtask

   function automatic logic [LANES*DATA_WIDTH-1:0] allLanes(input logic [DATA_WIDTH-1:0] a);
      return {LANES{a}};
   endfunction

   function automatic logic [LANES*DATA_WIDTH-1:0] rampBeat(input int b);
      logic [LANES*DATA_WIDTH-1:0] r;
      for (int j = 0; j < LANES; j++) r[DATA_WIDTH*j +: DATA_WIDTH] = DATA_WIDTH'(LANES*b + j);
      return r;
   endfunction

   task automatic sendVector(input logic [DATA_WIDTH-1:0] a);
      for (int b = 0; b < AMPS/LANES; b++) applyStimulus(1'b1, allLanes(a), 1'b1, 1'b0);
   endtask

   initial begin
      bit togglePat[7];
      rst_n         = 1'b0;
      clr           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      modelReset();

      // Reset state, including in_ready high while reset is asserted
      #1;
      checkValue("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
      checkOutput();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Corner-value vectors with out_ready held high
      sendVector(32'h0000_0001);
      checkValue("ones_sum", 64'(bus.out_sum), 64'h0_0000_0010);
      sendVector(32'hFFFF_FFFF);
      checkValue("neg1_sum", 64'(bus.out_sum), 64'hF_FFFF_FFF0);
      sendVector(32'h7FFF_FFFF);
      checkValue("maxpos_sum", 64'(bus.out_sum), 64'h7_FFFF_FFF0);
      sendVector(32'h8000_0000);
      checkValue("maxneg_sum", 64'(bus.out_sum), 64'h8_0000_0000);

      // Backpressure for three cycles, then consume while the next vector starts
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, rampBeat(0), 1'b0, 1'b0);
      for (int b = 0; b < AMPS/LANES; b++) applyStimulus(1'b1, rampBeat(b), 1'b1, 1'b0);
      checkValue("ramp_sum", 64'(bus.out_sum), 64'd120);

      // Gapped beats
      togglePat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      foreach (togglePat[i]) applyStimulus(togglePat[i], allLanes(32'd2), 1'b1, 1'b0);
      checkValue("gap_sum", 64'(bus.out_sum), 64'd32);

      // Asynchronous reset in the middle of a vector
      applyStimulus(1'b1, allLanes(32'd5), 1'b1, 1'b0);
      applyStimulus(1'b1, allLanes(32'd5), 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkValue("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
      checkValue("async_rst_sum", 64'(bus.out_sum), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sendVector(32'h0000_0001);
      checkValue("post_rst_sum", 64'(bus.out_sum), 64'd16);

      // Flush in the middle of a vector discards the beat presented with it
      for (int b = 0; b < 3; b++) applyStimulus(1'b1, allLanes(32'd7), 1'b1, 1'b0);
      applyStimulus(1'b1, allLanes(32'd7), 1'b1, 1'b1);
      sendVector(32'h0000_0003);
      checkValue("post_clr_sum", 64'(bus.out_sum), 64'd48);

      // Randomized traffic: gaps, backpressure and occasional flushes
      for (int i = 0; i < 400; i++) begin
         logic [LANES*DATA_WIDTH-1:0] d;
         for (int j = 0; j < LANES; j++) d[DATA_WIDTH*j +: DATA_WIDTH] = $urandom;
         applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 60) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/accumulator_stream.md
Name: accumulator_stream

Overview:
- Sequential, streaming successor to the combinational amplitude accumulator.
- Sums all 2**NUM_QUBIT signed state-vector amplitudes, delivered LANES per beat over a valid/ready stream.
- Produces one registered, sign-extended total per vector, for the Grover diffusion (mean) stage.
- Sits between the amplitude memory reader and the diffusion/inversion-about-mean unit.

Parameters:
- NUM_QUBIT, 4: vector holds 2**NUM_QUBIT amplitudes.
- DATA_WIDTH, 32: signed two's-complement amplitude width.
- LANES, 4: amplitudes per input beat. Power of two, 1 <= LANES <= 2**NUM_QUBIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  synchronous flush: drop the partial vector and any pending result.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*DATA_WIDTH  lane j at bits [DATA_WIDTH*(j+1)-1 -: DATA_WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_sum  out  DATA_WIDTH+NUM_QUBIT  signed vector total.

Behaviour:
- Derived constants: BEATS = 2**NUM_QUBIT / LANES; SUM_W = DATA_WIDTH+NUM_QUBIT; beat counter width = max(1, clog2(BEATS)).
- Arithmetic:
  - Each lane is sign-extended to SUM_W before addition.
  - SUM_W cannot overflow for 2**NUM_QUBIT terms, so no saturation is needed.
- Datapath:
  - beat_sum = combinational sum of the LANES lanes.
  - acc = SUM_W register holding the running total.
- FSM states:
  - ACCUM: accepting beats.
  - HOLD: result valid, waiting for out_ready.
- in_ready = (state==ACCUM) || (state==HOLD && out_ready). This gives full throughput: a new vector's first beat may be accepted in the same cycle the result is consumed.
- ACCUM, beat accepted, not last beat: acc <= acc + beat_sum; cnt <= cnt+1.
- ACCUM, beat accepted, last beat (cnt==BEATS-1):
  - out_sum <= acc + beat_sum; acc <= 0; cnt <= 0.
  - out_valid <= 1; go to HOLD.
  - Latency: out_valid rises on the clock edge after the last beat handshake.
- No beat accepted (in_valid low): all state holds. Gaps between beats are legal.
- HOLD, out_ready=0: out_valid, out_sum and in_ready(=0) are all held stable.
- HOLD, out_ready=1:
  - Result retires.
  - If a beat is accepted in the same cycle, it is processed as an ACCUM beat. If BEATS==1 it is also the last beat, so state stays HOLD with the new out_sum.
  - If no beat is accepted, out_valid <= 0 and the FSM returns to ACCUM.
- clr=1 (highest priority after reset):
  - acc <= 0, cnt <= 0, out_valid <= 0, state <= ACCUM.
  - out_sum holds its value.
  - Any beat presented that cycle is discarded.
- Reset (rst_n low, any time including mid-vector): state ACCUM, cnt 0, acc 0, out_valid 0, out_sum 0. in_ready is 1 while in reset and on the first cycle after reset.
- out_sum changes only on a last-beat update, or on reset.

Optional Feature:
- Macro ACCUMULATOR_STREAM_MEAN_OUT_EN.
- Defined:
  - Adds output port out_mean (out, DATA_WIDTH), the registered signed mean.
  - out_mean = (acc + beat_sum) >>> NUM_QUBIT (arithmetic shift, floor toward -inf), truncated to DATA_WIDTH.
  - Updated on the same edge as out_sum; reset value 0.
- Undefined: port absent, no mean logic.

Decomposition:
- Shared package/include accumulator_pkg:
  - clog2 function.
  - State encodings ACCUM=1'b0, HOLD=1'b1.
  - Lane-slice helper macro.
- One sub-module lane_sum:
  - Combinational, parameters LANES, DATA_WIDTH, SUM_W.
  - Sign-extends and sums the LANES lanes into SUM_W.
  - Instantiated once for beat_sum.

Test Plan (NUM_QUBIT=4, DATA_WIDTH=32, LANES=4, BEATS=4):
- All 16 amplitudes = 32'h1 over 4 back-to-back beats, out_ready=1 -> out_valid high one edge after beat 4; out_sum=36'h0_0000_0010; out_mean=1.
- All amplitudes 32'hFFFF_FFFF -> out_sum=36'hF_FFFF_FFF0 (-16), out_mean=32'hFFFF_FFFF. All 32'h7FFF_FFFF -> 36'h7_FFFF_FFF0. All 32'h8000_0000 -> 36'h8_0000_0000.
- Backpressure: out_ready=0 for 3 cycles after result -> out_valid and out_sum stable, in_ready=0. Then out_ready=1 with next beat valid -> beat accepted that cycle; second vector (lanes 0..15 = values 0..15) gives out_sum=120.
- in_valid toggled 1,0,0,1,0,1,1 carrying four beats of value 2 -> out_sum=32; no spurious out_valid before the 4th beat.
- After 2 beats of value 5: rst_n pulsed low asynchronously mid-cycle -> out_valid=0 and out_sum=0 immediately; next full vector of 1s gives out_sum=16, not 56.
- After 3 beats of value 7: clr=1 for one cycle with in_valid=1 -> beat discarded; next vector of 3s gives out_sum=48.
